// File: rtl/bridge_pkg.sv
// Shared constants, state encoding and line-lane helper for the Wishbone-to-line bridge.
package bridge_pkg;

  localparam int WORD_W           = 32;
  localparam int WORDS_PER_LINE   = 8;
  localparam int LINE_OFFSET_BITS = 5;
  localparam int LINE_W           = WORD_W * WORDS_PER_LINE;

  // Explicit encodings keep the state values stable for anyone probing the register.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ISSUE = 3'd1,
    RD_WAIT  = 3'd2,
    MERGE    = 3'd3,
    WR_ISSUE = 3'd4,
    WR_WAIT  = 3'd5,
    ACK      = 3'd6
  } state_t;

  // Top bit of word 'offset' inside a line; word 0 sits in the MSBs.
  function automatic logic [7:0] word_lane(input logic [2:0] offset);
    return 8'(LINE_W - 1 - WORD_W * int'(offset));
  endfunction

endpackage

// File: rtl/wb_line_merge.sv
// Byte-wise merge of one 32-bit Wishbone word into a 256-bit line.
module wb_line_merge
  import bridge_pkg::*;
(
  input  logic [LINE_W-1:0] line,
  input  logic [2:0]        offset,
  input  logic [WORD_W-1:0] wdata,
  input  logic [3:0]        sel,
  output logic [LINE_W-1:0] merged
);

  // Every byte of the line picks either the new data (selected word, enabled byte) or the old byte.
  for (genvar gi = 0; gi < WORDS_PER_LINE; gi++) begin : g_word
    for (genvar gj = 0; gj < 4; gj++) begin : g_byte
      localparam int LO = LINE_W - WORD_W * (gi + 1) + 8 * gj;
      assign merged[LO +: 8] = ((offset == 3'(gi)) && sel[gj]) ? wdata[8*gj +: 8]
                                                               : line[LO +: 8];
    end
  end

endmodule

// File: rtl/wb_line_bridge.sv
// Wishbone classic word slave in front of a line-wide memory port.
// Reads fill a one-line buffer; sub-word writes are read-modify-write, always written through.
module wb_line_bridge
  import bridge_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int LINE_WIDTH     = 256,
  parameter bit LINE_BUFFER_EN = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_we_i,
  input  logic [ADDR_WIDTH-1:0] wb_adr_i,
  input  logic [WORD_W-1:0]     wb_dat_i,
  input  logic [3:0]            wb_sel_i,
  output logic [WORD_W-1:0]     wb_dat_o,
  output logic                  wb_ack_o,
  output logic                  strobe_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [LINE_WIDTH-1:0] wdata_o,
  output logic                  rw_o,
  input  logic [LINE_WIDTH-1:0] rdata_i,
  input  logic                  done_i
);

  localparam int TAG_W = ADDR_WIDTH - LINE_OFFSET_BITS;

  state_t                state_reg;
  logic [TAG_W-1:0]      tag_reg;
  logic [2:0]            off_reg;
  logic [WORD_W-1:0]     dat_reg;
  logic [3:0]            sel_reg;
  logic                  we_reg;
  // Working line; whenever lb_valid_reg is set it is also the buffered copy of line lb_tag_reg.
  logic [LINE_WIDTH-1:0] line_reg;
  logic [TAG_W-1:0]      lb_tag_reg;
  logic                  lb_valid_reg;
  logic                  lb_hit;
  logic [LINE_WIDTH-1:0] merged_line;
  logic                  unused_adr_bits;

  // Byte address bits below the word are don't-care.
  assign unused_adr_bits = ^wb_adr_i[1:0];

  // Buffer hit on the incoming request's line.
  assign lb_hit = LINE_BUFFER_EN && lb_valid_reg &&
                  (lb_tag_reg == wb_adr_i[ADDR_WIDTH-1:LINE_OFFSET_BITS]);

  // Ack only if the master still holds the cycle; an abandoned cycle completes silently.
  assign wb_ack_o = (state_reg == ACK) && wb_cyc_i;

  wb_line_merge u_merge (
    .line   (line_reg),
    .offset (off_reg),
    .wdata  (dat_reg),
    .sel    (sel_reg),
    .merged (merged_line)
  );

  // Main sequencer: request capture, downstream handshakes, buffer upkeep, read data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      tag_reg      <= '0;
      off_reg      <= '0;
      dat_reg      <= '0;
      sel_reg      <= '0;
      we_reg       <= 1'b0;
      line_reg     <= '0;
      lb_tag_reg   <= '0;
      lb_valid_reg <= 1'b0;
      wb_dat_o     <= '0;
      strobe_o     <= 1'b0;
      addr_o       <= '0;
      wdata_o      <= '0;
      rw_o         <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (wb_cyc_i && wb_stb_i) begin
            tag_reg <= wb_adr_i[ADDR_WIDTH-1:LINE_OFFSET_BITS];
            off_reg <= wb_adr_i[4:2];
            dat_reg <= wb_dat_i;
            sel_reg <= wb_sel_i;
            we_reg  <= wb_we_i;
            addr_o  <= {wb_adr_i[ADDR_WIDTH-1:LINE_OFFSET_BITS], {LINE_OFFSET_BITS{1'b0}}};
            if (lb_hit && !wb_we_i) begin
              wb_dat_o  <= line_reg[word_lane(wb_adr_i[4:2]) -: WORD_W];
              state_reg <= ACK;
            end else if (lb_hit) begin
              // line_reg already holds the buffered line, so it is the merge base.
              state_reg <= MERGE;
            end else begin
              strobe_o  <= 1'b1;
              rw_o      <= 1'b0;
              state_reg <= RD_ISSUE;
            end
          end
        end
        RD_ISSUE: begin
          strobe_o  <= 1'b0;
          state_reg <= RD_WAIT;
        end
        RD_WAIT: begin
          if (done_i) begin
            line_reg     <= rdata_i;
            lb_tag_reg   <= tag_reg;
            lb_valid_reg <= 1'b1;
            if (we_reg) begin
              state_reg <= MERGE;
            end else begin
              wb_dat_o  <= rdata_i[word_lane(off_reg) -: WORD_W];
              state_reg <= ACK;
            end
          end
        end
        MERGE: begin
          // This cycle is also the turnaround the memory needs after done_i.
          line_reg  <= merged_line;
          wdata_o   <= merged_line;
          strobe_o  <= 1'b1;
          rw_o      <= 1'b1;
          state_reg <= WR_ISSUE;
        end
        WR_ISSUE: begin
          strobe_o  <= 1'b0;
          state_reg <= WR_WAIT;
        end
        WR_WAIT: begin
          if (done_i) begin
            state_reg <= ACK;
          end
        end
        ACK: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule
